regfile_wb_scheduler: RTL and testbench
=======================================

Name: regfile_wb_scheduler

Overview:
- Sits between the issue stage, the two writeback sources (ALU, load/store unit) and the single write port of the 31x32 integer register file (x0 hardwired zero).
- Keeps a per-register busy scoreboard and stalls issue on RAW/WAW hazards.
- Arbitrates the two writeback requesters round-robin onto the one write port.
- Drives the register file write port through a registered stage.

Parameters:
- NUM_REGS, 32, architectural register count; index 0 is never written or marked busy.
- REG_W, 5, register index width (t_register).
- XLEN, 32, data width (t_word).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous scoreboard clear.
- issue_valid  in  1  instruction requests issue.
- issue_rd  in  REG_W  destination register.
- issue_rs1  in  REG_W  source register 1.
- issue_rs2  in  REG_W  source register 2.
- issue_ready  out  1  issue accepted this cycle, combinational.
- alu_wb_valid  in  1  ALU result available.
- alu_wb_rd  in  REG_W  ALU destination register.
- alu_wb_data  in  XLEN  ALU result.
- alu_wb_ready  out  1  ALU grant, combinational.
- mem_wb_valid  in  1  load result available.
- mem_wb_rd  in  REG_W  load destination register.
- mem_wb_data  in  XLEN  load data.
- mem_wb_ready  out  1  load grant, combinational.
- rf_we  out  1  register file write enable.
- rf_reg_c  out  REG_W  register file write index.
- rf_data_c  out  XLEN  register file write data.
- busy_mask  out  NUM_REGS  scoreboard; bit 0 is always 0.
- wb_unexpected  out  1  one-cycle pulse: a write committed to a non-busy register.

Behaviour:
- Reset (rst_n low, asynchronous): busy_mask = 0, rf_we = 0, rf_reg_c = 0, rf_data_c = 0, wb_unexpected = 0, round-robin pointer = ALU.
- Combinational outputs while in reset: issue_ready, alu_wb_ready and mem_wb_ready are forced 0.
- Reset mid-operation: pending grants and busy bits are discarded; the in-flight write stage is dropped (rf_we goes 0 immediately).

Issue:
- issue_ready = issue_valid and not busy[rs1] and not busy[rs2] and not busy[rd].
- Index 0 is never busy, so x0 operands never stall.
- On accept with rd != 0, busy[rd] is set at that clock edge.

Arbitration (cycle T):
- Only one valid requester: it is granted.
- Both valid: the requester named by the pointer is granted. The pointer then flips to the other requester. The pointer is unchanged when only one requester is valid.
- ready is asserted only on the granted source. The source holds valid/rd/data stable until it sees ready.

Write stage:
- The granted rd/data are registered at the end of T.
- During T+1: rf_we = 1 if the granted rd != 0, else 0, with rf_reg_c/rf_data_c presented. The register file commits at the end of T+1.
- rd = 0 writeback: granted and consumed, no write, no scoreboard change.

Scoreboard clear:
- busy[rf_reg_c] is cleared at the end of T+1, the same edge the register file commits.
- In T+2 the issue stage sees the bit clear and the file holds the new value. No bypass path.
- Granted → visible-to-issue latency is 2 cycles.

Simultaneous events:
- Set and clear of the same register in one cycle cannot occur: a busy rd stalls issue.
- Set of one register and clear of another apply independently.

wb_unexpected:
- Pulses in T+1 when rf_we = 1 and busy[rf_reg_c] = 0.
- The write still commits.

flush:
- At the next edge all busy bits clear. flush has priority over an issue set in that cycle.
- The write stage and pointer are unaffected: an in-flight write still commits, and raises no wb_unexpected in that cycle.

Test Plan:
- Reset: drive rst_n low mid-write (rf_we=1, rf_reg_c=7) → rf_we=0, busy_mask=0 immediately. After release, issue rd=3 accepted same cycle.
- RAW stall: issue rd=5, then next cycle issue rs1=5 → issue_ready=0. ALU writes x5=0xDEADBEEF granted at T → rf_we=1, rf_reg_c=5 at T+1; issue_ready=1 at T+2; busy_mask[5]=0.
- Round-robin: ALU (rd=1, 0x11) and mem (rd=2, 0x22) both valid for 2 cycles from reset → grants ALU then mem. rf writes x1=0x11 at T+1, x2=0x22 at T+2. A third simultaneous pair is granted ALU first.
- x0: mem writeback rd=0, data 0xFFFFFFFF → mem_wb_ready=1, rf_we stays 0, busy_mask unchanged. Issue rs1=0, rs2=0, rd=0 → never stalls.
- Unexpected write: ALU writes rd=9 with busy[9]=0 → rf_we=1 and wb_unexpected=1 for exactly one cycle.
- Flush: busy on x4 and x6, flush=1 with simultaneous issue rd=8 → busy_mask=0 next cycle, including bit 8. Pending write of x4 still commits, no wb_unexpected.

Source files
------------

// File: rtl/regfile_wb_scheduler_if.sv
// Bundles the issue, writeback and register-file write-port signals of the
// writeback scheduler. The scheduler takes the slave view and its environment the master view.
interface regfile_wb_scheduler_if #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5,
  parameter int XLEN     = 32
);
  logic                flush;
  logic                issue_valid;
  logic [REG_W-1:0]    issue_rd;
  logic [REG_W-1:0]    issue_rs1;
  logic [REG_W-1:0]    issue_rs2;
  logic                issue_ready;
  logic                alu_wb_valid;
  logic [REG_W-1:0]    alu_wb_rd;
  logic [XLEN-1:0]     alu_wb_data;
  logic                alu_wb_ready;
  logic                mem_wb_valid;
  logic [REG_W-1:0]    mem_wb_rd;
  logic [XLEN-1:0]     mem_wb_data;
  logic                mem_wb_ready;
  logic                rf_we;
  logic [REG_W-1:0]    rf_reg_c;
  logic [XLEN-1:0]     rf_data_c;
  logic [NUM_REGS-1:0] busy_mask;
  logic                wb_unexpected;

  modport slave (
    input  flush, issue_valid, issue_rd, issue_rs1, issue_rs2,
    input  alu_wb_valid, alu_wb_rd, alu_wb_data,
    input  mem_wb_valid, mem_wb_rd, mem_wb_data,
    output issue_ready, alu_wb_ready, mem_wb_ready,
    output rf_we, rf_reg_c, rf_data_c, busy_mask, wb_unexpected
  );

  modport master (
    output flush, issue_valid, issue_rd, issue_rs1, issue_rs2,
    output alu_wb_valid, alu_wb_rd, alu_wb_data,
    output mem_wb_valid, mem_wb_rd, mem_wb_data,
    input  issue_ready, alu_wb_ready, mem_wb_ready,
    input  rf_we, rf_reg_c, rf_data_c, busy_mask, wb_unexpected
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Busy scoreboard, round-robin writeback arbitration and a registered write
// stage in front of the single register file write port.
module regfile_wb_scheduler #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5,
  parameter int XLEN     = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  regfile_wb_scheduler_if.slave  bus
);
  typedef logic [REG_W-1:0] t_register;
  typedef logic [XLEN-1:0]  t_word;
  typedef enum logic {PRI_ALU, PRI_MEM} pri_e;

  pri_e                ptr_q, ptr_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                we_q, we_d;
  t_register           reg_q, reg_d;
  t_word               data_q, data_d;
  logic                issue_ok, alu_gnt, mem_gnt;

  // Handshakes are forced low while reset is held.
  always_comb begin
    issue_ok = rst_n & bus.issue_valid & ~busy_q[bus.issue_rs1]
             & ~busy_q[bus.issue_rs2] & ~busy_q[bus.issue_rd];
    alu_gnt  = rst_n & bus.alu_wb_valid & (~bus.mem_wb_valid | (ptr_q == PRI_ALU));
    mem_gnt  = rst_n & bus.mem_wb_valid & (~bus.alu_wb_valid | (ptr_q == PRI_MEM));
  end

  always_comb begin
    busy_d = busy_q;
    ptr_d  = ptr_q;
    we_d   = 1'b0;
    reg_d  = reg_q;
    data_d = data_q;
    // The clear lands on the same edge the register file commits.
    if (we_q) busy_d[reg_q] = 1'b0;
    if (issue_ok && bus.issue_rd != '0) busy_d[bus.issue_rd] = 1'b1;
    if (bus.flush) busy_d = '0;
    busy_d[0] = 1'b0;
    if (alu_gnt) begin
      we_d   = (bus.alu_wb_rd != '0);
      reg_d  = bus.alu_wb_rd;
      data_d = bus.alu_wb_data;
    end else if (mem_gnt) begin
      we_d   = (bus.mem_wb_rd != '0);
      reg_d  = bus.mem_wb_rd;
      data_d = bus.mem_wb_data;
    end
    if (bus.alu_wb_valid && bus.mem_wb_valid)
      ptr_d = (ptr_q == PRI_ALU) ? PRI_MEM : PRI_ALU;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= PRI_ALU;
      busy_q <= '0;
      we_q   <= 1'b0;
      reg_q  <= '0;
      data_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      busy_q <= busy_d;
      we_q   <= we_d;
      reg_q  <= reg_d;
      data_q <= data_d;
    end
  end

  assign bus.issue_ready   = issue_ok;
  assign bus.alu_wb_ready  = alu_gnt;
  assign bus.mem_wb_ready  = mem_gnt;
  assign bus.rf_we         = we_q;
  assign bus.rf_reg_c      = reg_q;
  assign bus.rf_data_c     = data_q;
  assign bus.busy_mask     = busy_q;
  // A flush cycle never reports an unexpected write.
  assign bus.wb_unexpected = we_q & ~busy_q[reg_q] & ~bus.flush;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: a queue-based reference model is
// compared every negedge, plus hand-computed literal expectations per scenario.
module tb_regfile_wb_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  regfile_wb_scheduler_if bus ();
  regfile_wb_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  // Reference model: busy table, pending writes, and who has priority on a tie.
  bit  mb [32];
  wr_t inflight [$];
  bit  memHasPriority;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelBusy();
    logic [31:0] m;
    m = '0;
    for (int i = 1; i < 32; i++) m[i] = mb[i];
    return m;
  endfunction

  function automatic bit modelIssueOk();
    return rst_n && bus.issue_valid && !mb[bus.issue_rs1] && !mb[bus.issue_rs2] && !mb[bus.issue_rd];
  endfunction

  function automatic bit modelAluWins();
    if (!rst_n || !bus.alu_wb_valid) return 1'b0;
    return !bus.mem_wb_valid || !memHasPriority;
  endfunction

  function automatic bit modelMemWins();
    if (!rst_n || !bus.mem_wb_valid) return 1'b0;
    return !bus.alu_wb_valid || memHasPriority;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mb[i] = 1'b0;
      inflight.delete();
      memHasPriority = 1'b0;
    end else begin
      bit aluW, memW, iss;
      wr_t w;
      aluW = modelAluWins();
      memW = modelMemWins();
      iss  = modelIssueOk();
      if (inflight.size() > 0) begin
        mb[inflight[0].rd] = 1'b0;
        void'(inflight.pop_front());
      end
      if (iss && bus.issue_rd != 5'd0) mb[bus.issue_rd] = 1'b1;
      if (bus.flush) for (int i = 0; i < 32; i++) mb[i] = 1'b0;
      if (aluW && bus.alu_wb_rd != 5'd0) begin
        w.rd = bus.alu_wb_rd; w.data = bus.alu_wb_data; inflight.push_back(w);
      end else if (memW && bus.mem_wb_rd != 5'd0) begin
        w.rd = bus.mem_wb_rd; w.data = bus.mem_wb_data; inflight.push_back(w);
      end
      if (bus.alu_wb_valid && bus.mem_wb_valid) memHasPriority = !memHasPriority;
    end
  end

  always @(negedge clk) begin
    bit expWe;
    expWe = (inflight.size() > 0);
    checkOutput("issue_ready", 32'(bus.issue_ready), 32'(modelIssueOk()));
    checkOutput("alu_wb_ready", 32'(bus.alu_wb_ready), 32'(modelAluWins()));
    checkOutput("mem_wb_ready", 32'(bus.mem_wb_ready), 32'(modelMemWins()));
    checkOutput("rf_we", 32'(bus.rf_we), 32'(expWe));
    checkOutput("busy_mask", bus.busy_mask, modelBusy());
    if (expWe) begin
      checkOutput("rf_reg_c", 32'(bus.rf_reg_c), 32'(inflight[0].rd));
      checkOutput("rf_data_c", bus.rf_data_c, inflight[0].data);
      checkOutput("wb_unexpected", 32'(bus.wb_unexpected),
                  32'(!mb[inflight[0].rd] && !bus.flush));
    end else begin
      checkOutput("wb_unexpected", 32'(bus.wb_unexpected), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit iv, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input bit av, input logic [4:0] ard, input logic [31:0] adata,
                               input bit mv, input logic [4:0] mrd, input logic [31:0] mdata,
                               input bit fl);
    bus.issue_valid = iv; bus.issue_rd = rd; bus.issue_rs1 = rs1; bus.issue_rs2 = rs2;
    bus.alu_wb_valid = av; bus.alu_wb_rd = ard; bus.alu_wb_data = adata;
    bus.mem_wb_valid = mv; bus.mem_wb_rd = mrd; bus.mem_wb_data = mdata;
    bus.flush = fl;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idle();
    // Reset: handshakes forced low
    applyStimulus(1, 3, 0, 0, 1, 1, 32'h1, 0, 0, 0, 0);
    #2;
    checkOutput("rst issue_ready", 32'(bus.issue_ready), 32'd0);
    checkOutput("rst alu_ready", 32'(bus.alu_wb_ready), 32'd0);
    checkOutput("rst rf_we", 32'(bus.rf_we), 32'd0);
    checkOutput("rst busy", bus.busy_mask, 32'd0);
    tick(); tick();

    // Round-robin from reset
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h11, 1, 2, 32'h22, 0);
    #1;
    checkOutput("rr0 alu_ready", 32'(bus.alu_wb_ready), 32'd1);
    checkOutput("rr0 mem_ready", 32'(bus.mem_wb_ready), 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 10, 32'hA0, 1, 2, 32'h22, 0);
    #1;
    checkOutput("rr1 mem_ready", 32'(bus.mem_wb_ready), 32'd1);
    checkOutput("rr1 alu_ready", 32'(bus.alu_wb_ready), 32'd0);
    checkOutput("rr1 rf_reg_c", 32'(bus.rf_reg_c), 32'd1);
    checkOutput("rr1 rf_data_c", bus.rf_data_c, 32'h11);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 10, 32'hA0, 1, 11, 32'hB0, 0);
    #1;
    checkOutput("rr2 alu_ready", 32'(bus.alu_wb_ready), 32'd1);
    checkOutput("rr2 rf_reg_c", 32'(bus.rf_reg_c), 32'd2);
    checkOutput("rr2 rf_data_c", bus.rf_data_c, 32'h22);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 11, 32'hB0, 0);
    #1;
    checkOutput("rr3 mem_ready", 32'(bus.mem_wb_ready), 32'd1);
    checkOutput("rr3 rf_reg_c", 32'(bus.rf_reg_c), 32'd10);
    tick();
    idle();
    #1;
    checkOutput("rr4 rf_data_c", bus.rf_data_c, 32'hB0);
    tick();

    // RAW stall on x5
    applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("raw issue rd5", 32'(bus.issue_ready), 32'd1);
    tick();
    applyStimulus(1, 6, 5, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    #1;
    checkOutput("raw busy5 set", 32'(bus.busy_mask[5]), 32'd1);
    checkOutput("raw stall", 32'(bus.issue_ready), 32'd0);
    checkOutput("raw alu_ready", 32'(bus.alu_wb_ready), 32'd1);
    tick();
    applyStimulus(1, 6, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("raw T+1 rf_we", 32'(bus.rf_we), 32'd1);
    checkOutput("raw T+1 rf_reg_c", 32'(bus.rf_reg_c), 32'd5);
    checkOutput("raw T+1 rf_data_c", bus.rf_data_c, 32'hDEADBEEF);
    checkOutput("raw T+1 stall", 32'(bus.issue_ready), 32'd0);
    tick();
    #1;
    checkOutput("raw T+2 ready", 32'(bus.issue_ready), 32'd1);
    checkOutput("raw T+2 busy5", 32'(bus.busy_mask[5]), 32'd0);
    tick();
    idle();

    // x0 writeback and x0 operands
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 0);
    #1;
    checkOutput("x0 mem_ready", 32'(bus.mem_wb_ready), 32'd1);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("x0 rf_we", 32'(bus.rf_we), 32'd0);
    checkOutput("x0 busy", bus.busy_mask, 32'h40);
    checkOutput("x0 issue", 32'(bus.issue_ready), 32'd1);
    tick();
    idle();
    #1;
    checkOutput("x0 busy after", bus.busy_mask, 32'h40);

    // Unexpected write to non-busy x9
    applyStimulus(0, 0, 0, 0, 1, 9, 32'h99, 0, 0, 0, 0);
    tick();
    idle();
    #1;
    checkOutput("unexp rf_we", 32'(bus.rf_we), 32'd1);
    checkOutput("unexp pulse", 32'(bus.wb_unexpected), 32'd1);
    tick();
    #1;
    checkOutput("unexp gone", 32'(bus.wb_unexpected), 32'd0);

    // Flush with in-flight x4 write and simultaneous issue of x8
    applyStimulus(1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 4, 32'h44, 0, 0, 0, 0);
    #1;
    checkOutput("flush pre busy", bus.busy_mask, 32'h50);
    tick();
    applyStimulus(1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    checkOutput("flush rf_reg_c", 32'(bus.rf_reg_c), 32'd4);
    checkOutput("flush rf_we", 32'(bus.rf_we), 32'd1);
    checkOutput("flush no unexp", 32'(bus.wb_unexpected), 32'd0);
    tick();
    idle();
    #1;
    checkOutput("flush busy", bus.busy_mask, 32'd0);
    tick();

    // Reset mid-write, then issue x3
    applyStimulus(1, 12, 0, 0, 1, 7, 32'h77, 0, 0, 0, 0);
    tick();
    idle();
    #1;
    checkOutput("mid rf_reg_c", 32'(bus.rf_reg_c), 32'd7);
    checkOutput("mid busy", bus.busy_mask, 32'h1000);
    rst_n = 1'b0;
    #1;
    checkOutput("mid rst rf_we", 32'(bus.rf_we), 32'd0);
    checkOutput("mid rst busy", bus.busy_mask, 32'd0);
    tick();
    rst_n = 1'b1;
    applyStimulus(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("post rst issue", 32'(bus.issue_ready), 32'd1);
    tick();
    idle();
    #1;
    checkOutput("post rst busy", bus.busy_mask, 32'h8);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
